display_conv_sched: RTL and testbench

- Sequenced front-end for the 5-digit 7-segment output path.
- Arbitrates between two display sources: the CPU output word (valid/ack handshake) and the 8 board switches (selected by sw_sel).
- Converts the selected value to 5 BCD digits with a multi-cycle shift-add-3 (double-dabble) engine, replacing the combinational divide/modulo chain.
- Holds registered digit nibbles that feed the existing decodDisplay instances.

---
 rtl/display_pkg.sv | 16 +
 rtl/bcd_step.sv | 23 ++
 rtl/display_conv_sched.sv | 132 +++++++++++++
 tb/tb_display_conv_sched.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared types and constants for the 7-segment display conversion path.
package display_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  typedef logic [3:0] bcd_t;

  localparam int   NDIG      = 5;
  localparam bcd_t DIG_ERR   = 4'd14;
  localparam bcd_t DIG_BLANK = 4'd15;

endpackage

// File: rtl/bcd_step.sv
// One combinational double-dabble iteration: add 3 to every nibble >= 5,
// then shift the whole BCD vector left by one, taking bit_in as the new LSB.
module bcd_step
  import display_pkg::*;
(
  input  bcd_t [NDIG-1:0] bcd_in,
  input  logic            bit_in,
  output bcd_t [NDIG-1:0] bcd_out
);

  bcd_t [NDIG-1:0] adj;

  always_comb begin
    adj = bcd_in;
    for (int i = 0; i < NDIG; i++) begin
      if (bcd_in[i] >= 4'd5) adj[i] = bcd_in[i] + 4'd3;
    end
  end

  // The top adjusted bit falls off; values never exceed NDIG digits.
  assign bcd_out = (4*NDIG)'({adj, bit_in});

endmodule

// File: rtl/display_conv_sched.sv
// Arbitrates CPU word vs synchronized switches, converts to 5 BCD digits in CONV_BITS+1 cycles.
// cpu_ack only in IDLE; DISPLAY_LEADING_BLANK_EN blanks leading zero digits at commit.
module display_conv_sched
  import display_pkg::*;
#(
  parameter int IN_W      = 32,
  parameter int SW_W      = 8,
  parameter int MAX_VAL   = 99999,
  parameter int CONV_BITS = 17
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cpu_valid,
  input  logic [IN_W-1:0] cpu_data,
  output logic            cpu_ack,
  input  logic            sw_sel,
  input  logic [SW_W-1:0] chaves,
  output logic            busy,
  output logic            done,
  output logic [3:0]      dig0,
  output logic [3:0]      dig1,
  output logic [3:0]      dig2,
  output logic [3:0]      dig3,
  output logic [3:0]      dig4
);

  localparam int CNT_W = $clog2(CONV_BITS);

  state_t                 state, state_nx;
  logic [SW_W-1:0]        sw_m, sw_s, sw_prev;
  logic                   sw_sel_q;
  logic [IN_W-1:0]        cpu_shadow, operand;
  logic                   pending, set_pend, start, over, err;
  logic [CONV_BITS-1:0]   bin;
  logic [CNT_W-1:0]       count;
  bcd_t [NDIG-1:0]        bcd, bcd_nx, dig_nx, digs;

  bcd_step u_step (
    .bcd_in  (bcd),
    .bit_in  (bin[CONV_BITS-1]),
    .bcd_out (bcd_nx)
  );

  // CPU always wins in IDLE; with sw_sel=1 an accepted word only updates the shadow.
  always_comb begin
    state_nx = state;
    cpu_ack  = 1'b0;
    start    = 1'b0;
    operand  = sw_sel ? IN_W'(sw_s) : cpu_shadow;
    case (state)
      IDLE: begin
        if (cpu_valid) begin
          cpu_ack = 1'b1;
          if (!sw_sel) begin
            start   = 1'b1;
            operand = cpu_data;
          end
        end else if (pending) begin
          start = 1'b1;
        end
      end
      SHIFT:   if (count == CNT_W'(CONV_BITS-1)) state_nx = COMMIT;
      COMMIT:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    over = operand > IN_W'(MAX_VAL);
    if (start) state_nx = over ? COMMIT : SHIFT;
  end

  assign set_pend = (sw_sel != sw_sel_q) || (sw_sel && (sw_s != sw_prev)) ||
                    (cpu_ack && !sw_sel);

  always_comb begin
    logic lead;
    lead   = 1'b1;
    dig_nx = bcd;
`ifdef DISPLAY_LEADING_BLANK_EN
    for (int i = NDIG-1; i > 0; i--) begin
      if (lead && bcd[i] == 4'd0) dig_nx[i] = DIG_BLANK;
      else                         lead = 1'b0;
    end
`endif
    if (err) dig_nx = {NDIG{DIG_ERR}};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      sw_m       <= '0;
      sw_s       <= '0;
      sw_prev    <= '0;
      sw_sel_q   <= 1'b0;
      cpu_shadow <= '0;
      pending    <= 1'b0;
      err        <= 1'b0;
      bin        <= '0;
      bcd        <= '0;
      count      <= '0;
      done       <= 1'b0;
      digs       <= {NDIG{DIG_BLANK}};
    end else begin
      state    <= state_nx;
      sw_m     <= chaves;
      sw_s     <= sw_m;
      sw_prev  <= sw_s;
      sw_sel_q <= sw_sel;
      done     <= (state == COMMIT);
      if (cpu_ack) cpu_shadow <= cpu_data;
      if (set_pend)   pending <= 1'b1;
      else if (start) pending <= 1'b0;
      if (start) begin
        err   <= over;
        bin   <= operand[CONV_BITS-1:0];
        bcd   <= '0;
        count <= '0;
      end else if (state == SHIFT) begin
        bcd   <= bcd_nx;
        bin   <= {bin[CONV_BITS-2:0], 1'b0};
        count <= count + 1'b1;
      end
      if (state == COMMIT) digs <= dig_nx;
    end
  end

  assign busy = (state != IDLE);
  assign dig0 = digs[0];
  assign dig1 = digs[1];
  assign dig2 = digs[2];
  assign dig3 = digs[3];
  assign dig4 = digs[4];

endmodule

// File: tb/tb_display_conv_sched.sv
// Directed + randomized bench for display_conv_sched against a decimal-arithmetic model.
module tb_display_conv_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_valid = 1'b0;
  logic [31:0] cpu_data = '0;
  logic        sw_sel = 1'b0;
  logic [7:0]  chaves = '0;
  logic        cpu_ack, busy, done;
  logic [3:0]  dig0, dig1, dig2, dig3, dig4;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  display_conv_sched dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cpu_valid (cpu_valid),
    .cpu_data  (cpu_data),
    .cpu_ack   (cpu_ack),
    .sw_sel    (sw_sel),
    .chaves    (chaves),
    .busy      (busy),
    .done      (done),
    .dig0      (dig0),
    .dig1      (dig1),
    .dig2      (dig2),
    .dig3      (dig3),
    .dig4      (dig4)
  );

  // Expected {dig4..dig0} for a displayed value, from plain decimal arithmetic.
  function automatic logic [19:0] model(longint unsigned v);
    logic [19:0]     r;
    longint unsigned t;
    bit              lead;
    t    = v;
    lead = 1'b1;
    r    = '0;
    if (v > 99999) return {5{4'd14}};
    for (int i = 0; i < 5; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
`ifdef DISPLAY_LEADING_BLANK_EN
    for (int i = 4; i > 0; i--) begin
      if (lead && r[4*i +: 4] == 4'd0) r[4*i +: 4] = 4'd15;
      else lead = 1'b0;
    end
`endif
    return r;
  endfunction

  function automatic logic [19:0] digits();
    return {dig4, dig3, dig2, dig1, dig0};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Wait until the DUT has been idle for 8 consecutive cycles (covers synchronizer delay).
  task automatic wait_quiet(input string tag);
    int q;
    q = 0;
    for (int c = 0; c < 500 && q < 8; c++) begin
      @(negedge clk); #1;
      if (!busy && !done) q++;
      else q = 0;
    end
    check({tag, "_quiet"}, 64'(q >= 8), 64'd1);
  endtask

  // Returns number of cycles waited for cpu_ack (-1 on timeout); leaves cpu_valid high.
  task automatic wait_ack(output int waited);
    waited = -1;
    for (int c = 0; c < 200; c++) begin
      #1;
      if (cpu_ack) begin
        waited = c;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic cpu_send(input logic [31:0] v, input string tag);
    int w, lat;
    @(negedge clk);
    cpu_valid = 1'b1;
    cpu_data  = v;
    wait_ack(w);
    check({tag, "_ack_first_idle"}, 64'(w), 64'd0);
    @(negedge clk);
    cpu_valid = 1'b0;
    cpu_data  = $urandom;
    lat = 1;
    #1;
    while (!done && lat < 60) begin
      @(negedge clk); #1;
      lat++;
    end
    check({tag, "_latency"}, 64'(lat), (v > 99999) ? 64'd2 : 64'd19);
    check({tag, "_digits"}, 64'(digits()), 64'(model(v)));
    wait_quiet(tag);
    check({tag, "_digits_hold"}, 64'(digits()), 64'(model(v)));
  endtask

  initial begin
    logic [19:0] seen[$];
    logic [31:0] rv;
    int          w, dones, q;

    // Reset and idle.
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("reset_done", 64'(done), 64'd0);
    end
    check("reset_digits", 64'(digits()), 64'hFFFFF);
    check("reset_busy", 64'(busy), 64'd0);

    // CPU path, directed boundaries.
    cpu_send(32'd12345, "cpu_12345");
    cpu_send(32'd100000, "cpu_100000");
    cpu_send(32'd99999, "cpu_99999");
    cpu_send(32'd0, "cpu_0");

    // CPU path, random values with occasional overflow.
    for (int i = 0; i < 8; i++) begin
      rv = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 99999));
      cpu_send(rv, $sformatf("cpu_rand%0d", i));
    end

    // Switch path.
    @(negedge clk);
    sw_sel = 1'b1;
    chaves = 8'd255;
    wait_quiet("sw_255");
    check("sw_255_digits", 64'(digits()), 64'(model(255)));

    // Switch change mid-SHIFT produces a second conversion.
    @(negedge clk);
    chaves = 8'd100;
    w = -1;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk); #1;
      if (busy) begin w = c; break; end
    end
    check("sw_mid_busy_seen", 64'(w >= 0), 64'd1);
    repeat (5) @(negedge clk);
    chaves = 8'd7;
    seen.delete();
    q = 0;
    for (int c = 0; c < 500 && q < 8; c++) begin
      @(negedge clk); #1;
      if (done) seen.push_back(digits());
      if (!busy && !done) q++;
      else q = 0;
    end
    check("sw_mid_done_count", 64'(seen.size()), 64'd2);
    if (seen.size() == 2) begin
      check("sw_mid_first", 64'(seen[0]), 64'(model(100)));
      check("sw_mid_second", 64'(seen[1]), 64'(model(7)));
    end

    // CPU request during a switch conversion stalls until IDLE.
    @(negedge clk);
    chaves = 8'd42;
    w = -1;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk); #1;
      if (busy) begin w = c; break; end
    end
    check("stall_busy_seen", 64'(w >= 0), 64'd1);
    @(negedge clk);
    cpu_valid = 1'b1;
    cpu_data  = 32'd321;
    wait_ack(w);
    check("stall_ack_delayed", 64'(w > 0), 64'd1);
    check("stall_ack_not_busy", 64'(busy), 64'd0);
    @(negedge clk);
    cpu_valid = 1'b0;
    wait_quiet("stall");
    check("stall_digits_sw", 64'(digits()), 64'(model(42)));
    @(negedge clk);
    sw_sel = 1'b0;
    wait_quiet("shadow");
    check("shadow_digits", 64'(digits()), 64'(model(321)));

    // Reset in the middle of SHIFT discards the conversion.
    @(negedge clk);
    cpu_valid = 1'b1;
    cpu_data  = 32'd555;
    wait_ack(w);
    check("rst_mid_ack", 64'(w >= 0), 64'd1);
    @(negedge clk);
    cpu_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk); #1;
      if (done) dones++;
    end
    check("rst_mid_no_done", 64'(dones), 64'd0);
    check("rst_mid_digits", 64'(digits()), 64'hFFFFF);
    check("rst_mid_busy", 64'(busy), 64'd0);
    cpu_send(32'd777, "after_rst_777");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
